// File: rtl/conc_stim_seq.sv
// conc_stim_seq: replays a programmed vector table into a DUT one vector per
// step. Each table word is {hold, obs, data}. The block supports per-vector
// hold counts, multi-pass and continuous looping, pause and abort.
module conc_stim_seq #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 21,
  parameter int ADDR_W = 5,
  parameter int HOLD_W = 4,
  parameter int LOOP_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,         // async, active low
  input  logic                       i_load_en,
  input  logic [ADDR_W-1:0]          i_load_addr,
  input  logic [HOLD_W+DATA_W:0]     i_load_data,   // {hold, obs, data}
  input  logic [ADDR_W-1:0]          i_last_addr,
  input  logic [LOOP_W-1:0]          i_loops,
  input  logic                       i_loop_forever,
  input  logic                       i_start,
  input  logic                       i_pause,
  input  logic                       i_abort,
  output logic [DATA_W-1:0]          o_stim,
  output logic                       o_obs,
  output logic                       o_valid,
  output logic [ADDR_W-1:0]          o_pc,
  output logic                       o_done
);

  typedef struct packed {
    logic [HOLD_W-1:0] hold;
    logic              obs;
    logic [DATA_W-1:0] data;
  } word_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  // Table storage: not reset, survives rst so a replay after reset is identical.
  word_t r_mem [DEPTH];

  state_t              r_state,    w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr,      w_ptr_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
  logic [LOOP_W-1:0]   r_pass_cnt, w_pass_nxt;
  logic [ADDR_W-1:0]   r_last,     w_last_nxt;
  logic                r_forever,  w_forever_nxt;
  logic                r_final,    w_final_nxt;
  logic [DATA_W-1:0]   r_stim,     w_stim_nxt;
  logic                r_obs,      w_obs_nxt;
  logic                r_valid,    w_valid_nxt;
  logic [ADDR_W-1:0]   r_pc,       w_pc_nxt;
  logic                r_done,     w_done_nxt;
  word_t               w_word;
  logic                w_wr_ok;

  assign w_wr_ok = i_load_en && ({1'b0, i_load_addr} < DEPTH_C);

  // Table write port; writes land at the edge, so a same-cycle fetch sees old data.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[i_load_addr] <= word_t'(i_load_data);
  end

  // Next-state and output logic; abort overrides everything else.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_pass_nxt    = r_pass_cnt;
    w_last_nxt    = r_last;
    w_forever_nxt = r_forever;
    w_final_nxt   = r_final;
    w_stim_nxt    = r_stim;
    w_obs_nxt     = r_obs;
    w_valid_nxt   = r_valid;
    w_pc_nxt      = r_pc;
    w_done_nxt    = r_done;
    w_word        = r_mem[r_ptr];

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt   = S_RUN;
          w_ptr_nxt     = '0;
          w_hold_nxt    = '0;
          w_final_nxt   = 1'b0;
          w_last_nxt    = (i_last_addr > LAST_IDX) ? LAST_IDX : i_last_addr;
          w_pass_nxt    = i_loops;
          w_forever_nxt = i_loop_forever;
          w_done_nxt    = 1'b0;
        end
      end
      S_RUN: begin
        // pause freezes everything: no fetch, no hold countdown
        if (!i_pause) begin
          if (r_hold_cnt != '0) begin
            w_hold_nxt = r_hold_cnt - HOLD_W'(1);
          end else if (r_final) begin
            w_state_nxt = S_DONE;
            w_stim_nxt  = '0;
            w_obs_nxt   = 1'b0;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_stim_nxt  = w_word.data;
            w_obs_nxt   = w_word.obs;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = r_ptr;
            w_hold_nxt  = w_word.hold;
            if (r_ptr == r_last) begin
              // wrap directly to entry 0 so looping adds no bubble
              if (r_forever || (r_pass_cnt != '0)) begin
                w_ptr_nxt = '0;
                if (!r_forever) w_pass_nxt = r_pass_cnt - LOOP_W'(1);
              end else begin
                w_final_nxt = 1'b1;
              end
            end else begin
              w_ptr_nxt = r_ptr + ADDR_W'(1);
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_stim_nxt  = '0;
      w_obs_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_pc_nxt    = '0;
      w_ptr_nxt   = '0;
      w_hold_nxt  = '0;
      w_final_nxt = 1'b0;
    end
  end

  // State and output registers with async active-low clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_pass_cnt <= '0;
      r_last     <= '0;
      r_forever  <= 1'b0;
      r_final    <= 1'b0;
      r_stim     <= '0;
      r_obs      <= 1'b0;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_pass_cnt <= w_pass_nxt;
      r_last     <= w_last_nxt;
      r_forever  <= w_forever_nxt;
      r_final    <= w_final_nxt;
      r_stim     <= w_stim_nxt;
      r_obs      <= w_obs_nxt;
      r_valid    <= w_valid_nxt;
      r_pc       <= w_pc_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_stim  = r_stim;
  assign o_obs   = r_obs;
  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_done  = r_done;

endmodule

// File: tb/tb_conc_stim_seq.sv
// Directed bench for conc_stim_seq: basic replay, hold, looping, pause,
// abort, async reset and read-during-write behaviour.
module tb_conc_stim_seq;

  logic         clk;
  logic         rst;
  logic         load_en;
  logic [4:0]   load_addr;
  logic [132:0] load_data;
  logic [4:0]   last_addr;
  logic [7:0]   loops;
  logic         loop_forever;
  logic         start;
  logic         pause;
  logic         abort;
  logic [127:0] stim;
  logic         obs;
  logic         valid;
  logic [4:0]   pc;
  logic         done;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [127:0] A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] B = 128'hBBBB_0005_BBBB_0006_BBBB_0007_BBBB_0008;
  localparam logic [127:0] C = 128'hCCCC_0009_CCCC_000A_CCCC_000B_CCCC_000C;
  localparam logic [127:0] D = 128'hDDDD_000D_DDDD_000E_DDDD_000F_DDDD_0010;

  conc_stim_seq dut (
    .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_addr(load_addr),
    .i_load_data(load_data), .i_last_addr(last_addr), .i_loops(loops),
    .i_loop_forever(loop_forever), .i_start(start), .i_pause(pause),
    .i_abort(abort), .o_stim(stim), .o_obs(obs), .o_valid(valid),
    .o_pc(pc), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expv(input string tag, input logic [127:0] s, input logic o,
                      input logic v, input logic [4:0] p, input logic dn);
    chk({tag, ".stim"},  stim, s);
    chk({tag, ".obs"},   128'(obs), 128'(o));
    chk({tag, ".valid"}, 128'(valid), 128'(v));
    chk({tag, ".pc"},    128'(pc), 128'(p));
    chk({tag, ".done"},  128'(done), 128'(dn));
  endtask

  task automatic load(input logic [4:0] a, input logic [3:0] h, input logic o,
                      input logic [127:0] d);
    load_en = 1'b1; load_addr = a; load_data = {h, o, d};
    tick();
    load_en = 1'b0;
  endtask

  task automatic go(input logic [4:0] la, input logic [7:0] lp, input logic fv);
    last_addr = la; loops = lp; loop_forever = fv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    last_addr = '0; loops = '0; loop_forever = 1'b0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    #3 rst = 1'b0;
    #1 expv("reset", '0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    #2 rst = 1'b1;
    tick();
    expv("idle", '0, 1'b0, 1'b0, 5'd0, 1'b0);

    // basic replay A,B,C
    load(5'd0, 4'd0, 1'b1, A);
    load(5'd1, 4'd0, 1'b0, B);
    load(5'd2, 4'd0, 1'b1, C);
    go(5'd2, 8'd0, 1'b0);
    chk("basic.start_valid", 128'(valid), 128'd0);
    tick(); expv("basic.e1", A, 1'b1, 1'b1, 5'd0, 1'b0);
    tick(); expv("basic.e2", B, 1'b0, 1'b1, 5'd1, 1'b0);
    tick(); expv("basic.e3", C, 1'b1, 1'b1, 5'd2, 1'b0);
    tick(); expv("basic.e4", '0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick(); expv("basic.e5", '0, 1'b0, 1'b0, 5'd2, 1'b1);

    // hold: A for 4 cycles, B for 1, then done (restart from DONE)
    load(5'd0, 4'd3, 1'b1, A);
    go(5'd1, 8'd0, 1'b0);
    chk("hold.done_clr", 128'(done), 128'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); expv($sformatf("hold.A%0d", i), A, 1'b1, 1'b1, 5'd0, 1'b0);
    end
    tick(); expv("hold.B", B, 1'b0, 1'b1, 5'd1, 1'b0);
    tick(); expv("hold.done", '0, 1'b0, 1'b0, 5'd1, 1'b1);

    // loops=2: A,B x3 with no bubble, then done
    load(5'd0, 4'd0, 1'b1, A);
    go(5'd1, 8'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) expv($sformatf("loop.%0d", i), A, 1'b1, 1'b1, 5'd0, 1'b0);
      else            expv($sformatf("loop.%0d", i), B, 1'b0, 1'b1, 5'd1, 1'b0);
    end
    tick(); expv("loop.done", '0, 1'b0, 1'b0, 5'd1, 1'b1);

    // loop_forever: never done; start mid-run is ignored
    go(5'd1, 8'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 10) start = 1'b1;
      if (i == 11) start = 1'b0;
      chk($sformatf("fvr.stim%0d", i), stim, (i % 2 == 0) ? A : B);
      chk($sformatf("fvr.done%0d", i), 128'(done), 128'd0);
    end
    abort = 1'b1;
    tick(); expv("fvr.abort", '0, 1'b0, 1'b0, 5'd0, 1'b0);
    abort = 1'b0;

    // pause mid-hold of a hold=2 vector
    load(5'd0, 4'd2, 1'b1, A);
    go(5'd1, 8'd0, 1'b0);
    tick(); expv("pause.A0", A, 1'b1, 1'b1, 5'd0, 1'b0);
    tick(); expv("pause.A1", A, 1'b1, 1'b1, 5'd0, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); expv($sformatf("pause.frz%0d", i), A, 1'b1, 1'b1, 5'd0, 1'b0);
    end
    pause = 1'b0;
    tick(); expv("pause.A2", A, 1'b1, 1'b1, 5'd0, 1'b0);
    tick(); expv("pause.B", B, 1'b0, 1'b1, 5'd1, 1'b0);
    tick(); expv("pause.done", '0, 1'b0, 1'b0, 5'd1, 1'b1);

    // abort at pc=1, then replay from table[0]
    load(5'd0, 4'd0, 1'b1, A);
    go(5'd2, 8'd0, 1'b0);
    tick(); expv("abort.A", A, 1'b1, 1'b1, 5'd0, 1'b0);
    tick(); expv("abort.B", B, 1'b0, 1'b1, 5'd1, 1'b0);
    abort = 1'b1; start = 1'b1; pause = 1'b1;
    tick(); expv("abort.clr", '0, 1'b0, 1'b0, 5'd0, 1'b0);
    abort = 1'b0; start = 1'b0; pause = 1'b0;
    tick(); expv("abort.idle", '0, 1'b0, 1'b0, 5'd0, 1'b0);
    go(5'd2, 8'd0, 1'b0);
    tick(); expv("abort.rA", A, 1'b1, 1'b1, 5'd0, 1'b0);
    tick(); expv("abort.rB", B, 1'b0, 1'b1, 5'd1, 1'b0);
    tick(); expv("abort.rC", C, 1'b1, 1'b1, 5'd2, 1'b0);
    tick(); expv("abort.rdone", '0, 1'b0, 1'b0, 5'd2, 1'b1);

    // async reset mid-RUN
    go(5'd2, 8'd0, 1'b0);
    tick(); tick();
    chk("rst.pre_valid", 128'(valid), 128'd1);
    #2 rst = 1'b0;
    #1 expv("rst.async", '0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    #2 rst = 1'b1;
    tick(); expv("rst.idle", '0, 1'b0, 1'b0, 5'd0, 1'b0);
    go(5'd2, 8'd0, 1'b0);
    tick(); expv("rst.rA", A, 1'b1, 1'b1, 5'd0, 1'b0);
    tick(); expv("rst.rB", B, 1'b0, 1'b1, 5'd1, 1'b0);
    tick(); expv("rst.rC", C, 1'b1, 1'b1, 5'd2, 1'b0);
    tick(); expv("rst.rdone", '0, 1'b0, 1'b0, 5'd2, 1'b1);

    // write to the address being fetched: old data delivered, new data later
    go(5'd2, 8'd0, 1'b0);
    tick(); expv("rdw.A", A, 1'b1, 1'b1, 5'd0, 1'b0);
    load_en = 1'b1; load_addr = 5'd1; load_data = {4'd0, 1'b1, D};
    tick(); load_en = 1'b0;
    expv("rdw.old", B, 1'b0, 1'b1, 5'd1, 1'b0);
    tick(); expv("rdw.C", C, 1'b1, 1'b1, 5'd2, 1'b0);
    tick(); expv("rdw.done", '0, 1'b0, 1'b0, 5'd2, 1'b1);
    go(5'd2, 8'd0, 1'b0);
    tick(); expv("rdw.nA", A, 1'b1, 1'b1, 5'd0, 1'b0);
    tick(); expv("rdw.nD", D, 1'b1, 1'b1, 5'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/conc_stim_seq.md
# conc_stim_seq

Parametrised, synthesizable stimulus sequencer that replays a programmed vector table into a design under test, one vector per step, with a per-vector observe bit. It is the successor to the fixed 129-bit, 21-entry testbench replay loop. It adds configurable data width and table depth, per-vector hold counts, multi-pass and continuous looping, pause, and abort. It sits between the conquest harness and `top`: `stim` drives the DUT data input and `obs` drives `__obs`.

## Interface
- DATA_W, 128, stimulus data width
- DEPTH, 21, number of table entries
- ADDR_W, 5, table address width (2^ADDR_W >= DEPTH)
- HOLD_W, 4, per-vector hold field width
- LOOP_W, 8, pass-count width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- load_en  in  1  table write strobe
- load_addr  in  ADDR_W  table write address; writes with load_addr >= DEPTH are ignored
- load_data  in  HOLD_W+1+DATA_W  table word {hold, obs, data}
- last_addr  in  ADDR_W  last table index of a pass; sampled on start
- loops  in  LOOP_W  extra passes after the first; sampled on start
- loop_forever  in  1  wrap indefinitely; sampled on start
- start  in  1  begin playback (accepted in IDLE or DONE)
- pause  in  1  freeze playback while high
- abort  in  1  return to IDLE
- stim  out  DATA_W  current vector data
- obs  out  1  current vector observe bit
- valid  out  1  stim/obs carry a table vector
- pc  out  ADDR_W  table index of the vector on stim
- done  out  1  playback finished

## Operation
- Table: DEPTH x (HOLD_W+1+DATA_W) register array with one write port. Writes are accepted in any state and are not cleared by reset.
- Read and write to the same address in the same cycle: the fetch returns the old contents.
- States:
  - IDLE: outputs zero.
  - start -> RUN: internal pointer ptr=0, hold_cnt=0. Latches last_addr (clamped to DEPTH-1), loops into pass_cnt, and loop_forever.
  - RUN, hold_cnt==0 and pause low: fetch table[ptr] into stim/obs. Set pc<=ptr, valid<=1, hold_cnt<=word.hold.
    - If ptr==last_addr: if loop_forever or pass_cnt!=0, then ptr<=0 and pass_cnt decrements (unless forever). Otherwise set the final flag.
    - Else ptr<=ptr+1.
  - RUN, hold_cnt!=0 and pause low: hold_cnt decrements and outputs are held.
  - RUN, final flag set and hold_cnt==0: -> DONE. stim, obs and valid go to 0. done<=1, and pc keeps the last index.
  - DONE: done stays high until start (-> RUN, done<=0) or abort/reset.
- pause high in RUN: no fetch, no decrement, all outputs held, valid stays 1.
- abort in any state: -> IDLE next edge; stim, obs, valid, done, pc, ptr, hold_cnt all go to 0. abort has priority over start and pause.
- start while in RUN is ignored.
- Each vector is presented for hold+1 unpaused cycles.

## Timing
- Reset (rst=0): async clear of state (to IDLE), stim, obs, valid, pc, done, ptr, hold_cnt, pass_cnt and the latched config. Table contents are retained.
- Start latency: start high at edge k -> table[0] on stim at edge k+1.
- Vector n+1 appears exactly hold_n+1 unpaused cycles after vector n.
- done rises one edge after the final vector's last hold cycle.
- Loop wrap adds no bubble: table[last_addr] is followed directly by table[0].
- A pass covers last_addr+1 vectors. Total passes are loops+1, or unbounded with loop_forever.
- rst deasserted mid-cycle: the block is in IDLE at the first edge and waits for start.

## Test plan
- Load table[0..2] = {0,1,A}, {0,0,B}, {0,1,C}; last_addr=2, loops=0; start at edge 0. Required: stim=A,B,C with obs=1,0,1 at edges 1-3, valid high at edges 1-3, done=1 from edge 4, pc=0,1,2 then held at 2.
- Hold: table[0].hold=3, table[1].hold=0, last_addr=1. Required: A for 4 cycles, B for 1 cycle, then done.
- Loops=2, last_addr=1, holds 0. Required: sequence A,B,A,B,A,B with no bubble at wrap, then done; loop_forever=1 never asserts done.
- pause high for 5 cycles mid-hold of a hold=2 vector. Required: outputs frozen, the vector still totals 3 unpaused cycles, and the next vector follows directly.
- abort during RUN at pc=1. Required: next edge shows all outputs 0, state IDLE; a later start replays from table[0].
- Async reset pulse mid-RUN. Required: outputs 0 immediately, table retained, a later start replays the identical sequence. A write to the address being fetched in the same cycle delivers the old data.
